// File: rtl/vga_pixel_fetch.sv
// Pixel back-end for the VGA path. Takes per-pixel timing from the sync
// generator and fetches packed 4-bit colour indices from a synchronous
// framebuffer RAM. It maps each index through a 16-entry palette that the CPU
// can write, and drives registered 12-bit RGB together with delay-matched,
// polarity-adjusted sync.
module vga_pixel_fetch #(
  parameter int          ADDR_W       = 19,
  parameter int          PIX_PER_WORD = 4,
  parameter int          DATA_W       = 16,
  parameter bit          HS_NEG       = 1'b1,
  parameter bit          VS_NEG       = 1'b1,
  parameter logic [11:0] BORDER_RGB   = 12'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk25en,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              de_in,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic              mem_rd,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              pal_we,
  input  logic [3:0]        pal_waddr,
  input  logic [11:0]       pal_wdata,
  output logic [11:0]       rgb_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              de_out
);

  localparam int LANE_W  = $clog2(PIX_PER_WORD);
  localparam int WADDR_W = ADDR_W - 2;

  // Select the 4-bit colour index for one lane of a packed word; lane 0 sits
  // in the least significant nibble.
  function automatic logic [3:0] pick_nibble(input logic [DATA_W-1:0] word,
                                             input logic [LANE_W-1:0] lane);
    pick_nibble = word[int'(lane)*4 +: 4];
  endfunction

  // Convert an active-high sync into pin polarity.
  function automatic logic apply_pol(input logic sync_hi, input logic neg);
    apply_pol = sync_hi ^ neg;
  endfunction

  // Stage 0 state: timing, lane and the fetch flag for stage 1.
  logic              vld_p0_q;
  logic              hs_p0_q;
  logic              vs_p0_q;
  logic              fetch_p0_q;
  logic [LANE_W-1:0] lane_p0_q;

  // Framebuffer address is held between fetches.
  logic [WADDR_W-1:0] maddr_q;
  logic [WADDR_W-1:0] maddr_d;
  logic               fetch_d;

  // Stage 1 state: the held word and the selected colour index.
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] word_src;
  logic              vld_p1_q;
  logic              hs_p1_q;
  logic              vs_p1_q;
  logic [3:0]        idx_p1_q;

  // Stage 2 state: the registered pin outputs.
  logic [11:0] rgb_p2_q;
  logic        hs_p2_q;
  logic        vs_p2_q;
  logic        vld_p2_q;

  // Palette storage. It has no reset; software loads it before display.
  logic [11:0] pal_mem [16];
  logic [11:0] pal_rd;

  // A fetch is needed at the start of every word, and also on the first pixel
  // of a run. That covers a line that begins mid-word and the first pixel
  // after reset. The read strobe is combinational, so the RAM samples it on
  // the same edge that advances stage 0. Its data is therefore ready by the
  // next tick, even when clk25en is high on every clk.
  always_comb begin
    fetch_d = clk25en & de_in &
              ((pix_addr[LANE_W-1:0] == '0) | ~vld_p0_q);
    maddr_d = fetch_d ? pix_addr[ADDR_W-1:2] : maddr_q;
  end

  // The framebuffer strobe and address are forced to their idle values while
  // reset is held, so an asserted reset takes effect without waiting for a clock.
  assign mem_rd   = fetch_d & ~reset;
  assign mem_addr = reset ? '0 : maddr_d;

  // ---- stage 0: register pixel timing and the fetch decision ----
  // Capture the incoming pixel's timing and decide whether its word is fetched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0_q   <= 1'b0;
      hs_p0_q    <= 1'b0;
      vs_p0_q    <= 1'b0;
      fetch_p0_q <= 1'b0;
      lane_p0_q  <= '0;
      maddr_q    <= '0;
    end else if (clk25en) begin
      vld_p0_q   <= de_in;
      hs_p0_q    <= hsync_in;
      vs_p0_q    <= vsync_in;
      fetch_p0_q <= fetch_d;
      lane_p0_q  <= pix_addr[LANE_W-1:0];
      maddr_q    <= maddr_d;
    end
  end

  // A freshly fetched word is used directly. Otherwise the held word serves
  // the remaining lanes.
  always_comb begin
    word_src = fetch_p0_q ? mem_rdata : word_q;
  end

  // ---- stage 1: capture the RAM word and select the lane's index ----
  // Load the word register on fetch ticks and pick this pixel's nibble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q   <= '0;
      vld_p1_q <= 1'b0;
      hs_p1_q  <= 1'b0;
      vs_p1_q  <= 1'b0;
      idx_p1_q <= '0;
    end else if (clk25en) begin
      word_q   <= word_src;
      vld_p1_q <= vld_p0_q;
      hs_p1_q  <= hs_p0_q;
      vs_p1_q  <= vs_p0_q;
      idx_p1_q <= pick_nibble(word_src, lane_p0_q);
    end
  end

  // The palette write port runs on every clk and ignores clk25en.
  always_ff @(posedge clk) begin
    if (pal_we) begin
      pal_mem[pal_waddr] <= pal_wdata;
    end
  end

  // A write to the entry being looked up in the same clk is forwarded, so the
  // pixel shows the new colour (write-first).
  always_comb begin
    pal_rd = pal_mem[idx_p1_q];
    if (pal_we && (pal_waddr == idx_p1_q)) begin
      pal_rd = pal_wdata;
    end
  end

  // ---- stage 2: palette lookup, border colour and sync polarity ----
  // Register the final colour and the delay-matched sync and enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_p2_q <= BORDER_RGB;
      hs_p2_q  <= HS_NEG;
      vs_p2_q  <= VS_NEG;
      vld_p2_q <= 1'b0;
    end else if (clk25en) begin
      rgb_p2_q <= vld_p1_q ? pal_rd : BORDER_RGB;
      hs_p2_q  <= apply_pol(hs_p1_q, HS_NEG);
      vs_p2_q  <= apply_pol(vs_p1_q, VS_NEG);
      vld_p2_q <= vld_p1_q;
    end
  end

  assign rgb_out   = rgb_p2_q;
  assign hsync_out = hs_p2_q;
  assign vsync_out = vs_p2_q;
  assign de_out    = vld_p2_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Testbench for vga_pixel_fetch. It has two instances (active-low and
// active-high sync with different border colours) sharing one stimulus.
// A scoreboard queue records each sampled pixel, and a monitor pops and
// checks it when the pipeline presents it. Expected colours come from a
// framebuffer array and a palette model in this bench.
module tb_vga_pixel_fetch;

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [3:0] idx;
  } pix_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk25en;
  logic        hsync_in, vsync_in, de_in;
  logic [18:0] pix_addr;
  logic        pal_we;
  logic [3:0]  pal_waddr;
  logic [11:0] pal_wdata;

  logic        mem_rd, mem_rd2;
  logic [16:0] mem_addr, mem_addr2;
  logic [15:0] mem_rdata, mem_rdata2;
  logic [11:0] rgb, rgb2;
  logic        hs_o, vs_o, de_o, hs2, vs2, de2;

  logic [15:0] ram [256];
  logic [11:0] pal_m [16];
  pix_t        q [$];
  logic        prev_de;
  logic [16:0] last_addr;
  logic        tick_seen;
  int          checks = 0;
  int          errors = 0;
  int          div = 1;

  vga_pixel_fetch dut (
    .clk(clk), .reset(reset), .clk25en(clk25en),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in), .pix_addr(pix_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
    .rgb_out(rgb), .hsync_out(hs_o), .vsync_out(vs_o), .de_out(de_o)
  );

  vga_pixel_fetch #(.HS_NEG(1'b0), .VS_NEG(1'b0), .BORDER_RGB(12'hABC)) dut2 (
    .clk(clk), .reset(reset), .clk25en(clk25en),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in), .pix_addr(pix_addr),
    .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
    .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
    .rgb_out(rgb2), .hsync_out(hs2), .vsync_out(vs2), .de_out(de2)
  );

  always #5 clk = ~clk;

  // Synchronous framebuffer: data appears one clk after the read strobe.
  always @(posedge clk) begin
    if (mem_rd)  mem_rdata  <= ram[mem_addr[7:0]];
    if (mem_rd2) mem_rdata2 <= ram[mem_addr2[7:0]];
  end

  function automatic logic [3:0] idx_of(input logic [18:0] a);
    logic [15:0] s;
    s = ram[a[9:2]] >> {a[1:0], 2'b00};
    return s[3:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: record every sampled pixel, the last fetched address and the palette.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      q.push_back('0);
      q.push_back('0);
      prev_de   <= 1'b0;
      last_addr <= '0;
      tick_seen <= 1'b0;
    end else begin
      tick_seen <= clk25en;
      if (clk25en) begin
        q.push_back({de_in, hsync_in, vsync_in, de_in ? idx_of(pix_addr) : 4'h0});
        prev_de <= de_in;
        if (de_in && (pix_addr[1:0] == 2'd0 || !prev_de)) last_addr <= pix_addr[18:2];
      end
    end
    if (pal_we) pal_m[pal_waddr] <= pal_wdata;
  end

  // Monitor: check fetch strobes every clk and the pixel outputs on each tick.
  logic        exp_rd, prev_ok = 1'b0;
  logic [16:0] exp_addr;
  logic [11:0] sv_rgb, sv_rgb2;
  logic        sv_hs, sv_vs, sv_de;
  pix_t        e;
  always @(negedge clk) begin
    if (reset) begin
      prev_ok = 1'b0;
    end else begin
      exp_rd   = clk25en & de_in & ((pix_addr[1:0] == 2'd0) | ~prev_de);
      exp_addr = exp_rd ? pix_addr[18:2] : last_addr;
      chk("mem_rd", {31'd0, mem_rd}, {31'd0, exp_rd});
      chk("mem_addr", {15'd0, mem_addr}, {15'd0, exp_addr});
      if (tick_seen) begin
        if (q.size() < 3) begin
          chk("scoreboard_depth", q.size(), 3);
        end else begin
          e = q.pop_front();
          chk("rgb_out", {20'd0, rgb}, {20'd0, e.de ? pal_m[e.idx] : 12'h000});
          chk("hsync_out", {31'd0, hs_o}, {31'd0, ~e.hs});
          chk("vsync_out", {31'd0, vs_o}, {31'd0, ~e.vs});
          chk("de_out", {31'd0, de_o}, {31'd0, e.de});
          chk("rgb_out_pos", {20'd0, rgb2}, {20'd0, e.de ? pal_m[e.idx] : 12'hABC});
          chk("hsync_out_pos", {31'd0, hs2}, {31'd0, e.hs});
          chk("vsync_out_pos", {31'd0, vs2}, {31'd0, e.vs});
          chk("de_out_pos", {31'd0, de2}, {31'd0, e.de});
        end
      end else if (prev_ok) begin
        chk("hold_rgb", {20'd0, rgb}, {20'd0, sv_rgb});
        chk("hold_rgb_pos", {20'd0, rgb2}, {20'd0, sv_rgb2});
        chk("hold_sync", {29'd0, hs_o, vs_o, de_o}, {29'd0, sv_hs, sv_vs, sv_de});
      end
      sv_rgb = rgb; sv_rgb2 = rgb2; sv_hs = hs_o; sv_vs = vs_o; sv_de = de_o;
      prev_ok = 1'b1;
    end
  end

  // One pixel: inputs held for div clks, with the tick on the last of them.
  task automatic pix(input logic de, input logic [18:0] a, input logic hs, input logic vs);
    for (int k = 0; k < div; k++) begin
      de_in = de; pix_addr = a; hsync_in = hs; vsync_in = vs;
      clk25en = (k == div - 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(1'b0, 19'd0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_rgb"}, {20'd0, rgb}, 32'h000);
    chk({nm, "_rgb_pos"}, {20'd0, rgb2}, 32'hABC);
    chk({nm, "_sync"}, {29'd0, hs_o, vs_o, de_o}, 32'b110);
    chk({nm, "_sync_pos"}, {29'd0, hs2, vs2, de2}, 32'b000);
    chk({nm, "_mem_rd"}, {31'd0, mem_rd}, 32'd0);
    chk({nm, "_mem_addr"}, {15'd0, mem_addr}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t limit %0d", $time, 1_000_000);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clk25en = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0; de_in = 1'b0;
    pix_addr = '0; pal_we = 1'b0; pal_waddr = '0; pal_wdata = '0;
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;

    // Reset held with clk25en high: outputs stay at reset values.
    repeat (10) begin
      @(negedge clk);
      chk_reset_vals("reset_hold");
    end
    @(posedge clk); #1;
    reset = 1'b0; clk25en = 1'b0;

    // Palette[i] = i * 0x111.
    for (int i = 0; i < 16; i++) begin
      pal_we = 1'b1; pal_waddr = 4'(i); pal_wdata = 12'(i * 12'h111);
      @(posedge clk); #1;
    end
    pal_we = 1'b0;

    // Sequential line 0..7 at full rate.
    ram[0] = 16'h3210; ram[1] = 16'h7654; ram[2] = 16'hFEDC;
    div = 1;
    for (int a = 0; a < 8; a++) pix(1'b1, 19'(a), 1'b0, 1'b0);
    idle(4);

    // Line starting mid-word at address 6.
    ram[1] = 16'hBA98;
    for (int a = 6; a < 10; a++) pix(1'b1, 19'(a), 1'b0, 1'b0);
    idle(4);

    // Same as the first line with a tick every 4th clk.
    ram[1] = 16'h7654;
    div = 4;
    for (int a = 0; a < 8; a++) pix(1'b1, 19'(a), 1'b0, 1'b0);
    idle(4);
    div = 1;

    // 95-tick hsync pulse, then a short vsync pulse.
    for (int i = 0; i < 95; i++) pix(1'b0, 19'd0, 1'b1, 1'b0);
    idle(2);
    for (int i = 0; i < 5; i++) pix(1'b0, 19'd0, 1'b0, 1'b1);
    idle(4);

    // Palette write to entry 5 on the clk where index 5 loads into stage 2.
    ram[2] = 16'h5555;
    pix(1'b1, 19'd8, 1'b0, 1'b0);
    pix(1'b1, 19'd9, 1'b0, 1'b0);
    pal_we = 1'b1; pal_waddr = 4'd5; pal_wdata = 12'hF0F;
    pix(1'b1, 19'd10, 1'b0, 1'b0);
    pal_we = 1'b0;
    pix(1'b1, 19'd11, 1'b0, 1'b0);
    idle(4);

    // Reset mid-line, then resume mid-word: the first pixel must fetch again.
    ram[3] = 16'h1234; ram[4] = 16'hC3A5;
    pix(1'b1, 19'd12, 1'b1, 1'b0);
    pix(1'b1, 19'd13, 1'b1, 1'b0);
    pix(1'b1, 19'd14, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int a = 14; a < 19; a++) pix(1'b1, 19'(a), 1'b0, 1'b0);
    idle(4);

    // Randomised lines, tick spacing, sync and palette traffic.
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
    for (int ln = 0; ln < 60; ln++) begin
      int unsigned start, len;
      start = $urandom_range(0, 500000);
      len   = $urandom_range(1, 40);
      if ($urandom_range(0, 3) == 0) ram[$urandom_range(0, 255)] = 16'($urandom);
      for (int p = 0; p < int'(len); p++) begin
        div = $urandom_range(1, 4);
        if ($urandom_range(0, 15) == 0) begin
          pal_we = 1'b1; pal_waddr = 4'($urandom); pal_wdata = 12'($urandom);
        end
        pix(1'b1, 19'(start + p), ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
        pal_we = 1'b0;
      end
      for (int g = 0; g < int'($urandom_range(1, 5)); g++) begin
        div = $urandom_range(1, 4);
        pix(1'b0, 19'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
      end
    end
    div = 1;
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Pixel back-end directly downstream of the VGA sync generator.
- Consumes per-pixel timing (pixel-clock enable, hsync, vsync, display-enable, linear pixel address). Fetches packed 4-bit colour indices from a synchronous framebuffer RAM and maps them through a 16-entry CPU-writable palette.
- Drives registered 12-bit RGB plus delay-matched, polarity-adjusted sync to the DAC/pins.

Parameters:
- ADDR_W, 19, width of the incoming linear pixel address.
- PIX_PER_WORD, 4, pixels packed per framebuffer word (fixed 4 in this revision; 4 bits each, pixel 0 in bits [3:0]).
- DATA_W, 16, framebuffer word width (= 4*PIX_PER_WORD).
- HS_NEG, 1, 1 = hsync_out active-low.
- VS_NEG, 1, 1 = vsync_out active-low.
- BORDER_RGB, 12'h000, colour driven while display disabled.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- clk25en  in  1  pixel tick; all pixel-pipeline stages advance only when high
- hsync_in  in  1  active-high hsync from sync generator
- vsync_in  in  1  active-high vsync from sync generator
- de_in  in  1  display enable for current pixel
- pix_addr  in  ADDR_W  linear pixel index of current pixel, valid with de_in
- mem_rd  out  1  framebuffer read strobe, one clk wide
- mem_addr  out  ADDR_W-2  framebuffer word address
- mem_rdata  in  DATA_W  read data, valid exactly 1 clk after mem_rd
- pal_we  in  1  palette write strobe (clk domain, independent of clk25en)
- pal_waddr  in  4  palette entry
- pal_wdata  in  12  {R[3:0],G[3:0],B[3:0]}
- rgb_out  out  12  pixel colour
- hsync_out  out  1  delayed, polarity-adjusted hsync
- vsync_out  out  1  delayed, polarity-adjusted vsync
- de_out  out  1  delayed display enable

Behaviour:
- Reset (async): all pipeline regs, word register and de_out go to 0. rgb_out = BORDER_RGB. hsync_out = HS_NEG, vsync_out = VS_NEG (inactive). mem_rd = 0, mem_addr = 0. Palette is NOT reset; contents undefined until written.
- Pipeline: 3 stages, each advancing on clk cycles where clk25en = 1. Inputs sampled at tick N appear on outputs after tick N+2, i.e. latency = 3 ticks. hsync/vsync/de take the same 3-tick delay so they stay aligned with rgb.
- S0 (tick):
  - Register de, hs, vs, lane = pix_addr[1:0].
  - Fetch condition: de_in & (pix_addr[1:0]==0 | !de_s0_prev), where de_s0_prev is de_in from the previous tick.
  - On fetch, pulse mem_rd for exactly this clk and set mem_addr = pix_addr[ADDR_W-1:2]. This means a line starting mid-word still fetches.
  - Record a fetch flag for S1. mem_addr holds its value between fetches.
- S1 (tick):
  - If the fetch flag is set, capture mem_rdata into the word register; it is valid by then because tick spacing ≥ 1 clk.
  - Select index = nibble[lane], taken from the freshly captured word when the fetch flag is set, otherwise from the held word register.
- S2 (tick):
  - rgb_out = de ? palette[index] : BORDER_RGB.
  - hsync_out = hs ^ HS_NEG, vsync_out = vs ^ VS_NEG, de_out = de.
- Palette:
  - 16x12 regfile; write on any clk where pal_we = 1, regardless of clk25en.
  - Read-during-write to the same entry in the S2 load cycle returns the new pal_wdata (write-first).
- clk25en low: all outputs and pipeline state hold; mem_rd stays 0.
- clk25en permanently high (pixel clock = clk) is supported; the 1-clk RAM latency still meets S1 capture.
- de_in low: no fetches and the word register holds. rgb_out goes to BORDER_RGB 3 ticks later.
- Reset asserted mid-line: outputs go to reset values immediately. After release, the first de_in tick always fetches because de_s0_prev = 0.

Test Plan:
- Reset with clk25en=1 → rgb_out=12'h000, hsync_out=1, vsync_out=1, de_out=0, mem_rd=0; hold for 10 clk, no change.
- Palette[i]=i*12'h111. de_in=1 with pix_addr 0..7 on consecutive ticks, RAM word0=16'h3210, word1=16'h7654 → mem_rd exactly at addr 0 (mem_addr=0) and addr 4 (mem_addr=1). rgb_out = 000,111,…,777 starting 3 ticks after the first input tick.
- Line starting at pix_addr=6 (de_in rising), word1=16'hBA98 → fetch at mem_addr=1 on that tick; first rgb = palette[A], then palette[B], then fetch at addr 8.
- clk25en asserted every 4th clk with the same stimulus as scenario 2 → identical output sequence per tick; mem_rd one clk wide; outputs stable between ticks.
- hsync_in pulse of 95 ticks → hsync_out low for exactly 95 ticks, starting 3 ticks later. With HS_NEG=0 it is a high pulse instead.
- pal_we to entry 5 with 12'hF0F, on the same clk as the S2 load of index 5 → rgb_out=12'hF0F (write-first). Assert reset mid-frame → outputs go to reset values asynchronously; the first pixel after release re-fetches.
